pkt_fifo_sched: RTL and testbench



---
 rtl/pkt_fifo_pkg.sv | 24 ++
 rtl/pkt_fifo_sched_rr_arbiter.sv | 28 ++
 rtl/pkt_fifo_sched.sv | 139 +++++++++++++
 tb/tb_pkt_fifo_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared types for the packet FIFO scheduler: FSM states, port-op encoding, last-flag position.
// No logic; imported by the scheduler and its arbiter.
// Backpressure: n/a.
package pkt_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    // The end-of-packet flag sits directly above the payload in each FIFO word.
    localparam int unsigned LAST_BIT   = DEF_DATA_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } wr_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    function automatic int last_bit_idx(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/pkt_fifo_sched_rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping N-1 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to sample the grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!gnt_vld && req[(int'(ptr) + i) % N]) begin
                gnt_vld                   = 1'b1;
                gnt_idx                   = IW'((int'(ptr) + i) % N);
                gnt[(int'(ptr) + i) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_fifo_sched.sv
// Packet scheduler: round-robin N_SRC sources into a shared FIFO, one consumer out, counts whole packets.
// Latency: write beat same cycle as ready; read data one cycle after rd_en.
// Backpressure: source ready low while FIFO full or read slot wins; consumer cannot stall after rd_en.
module pkt_fifo_sched
    import pkt_fifo_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 13,
    parameter bit STORE_FWD = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_SRC-1:0]          i_src_valid,
    input  logic [N_SRC-1:0]          i_src_last,
    input  logic [N_SRC*DATA_W-1:0]   i_src_data,
    output logic [N_SRC-1:0]          o_src_ready,
    output logic                      o_fifo_wr_en,
    output logic [DATA_W:0]           o_fifo_wr_data,
    output logic                      o_fifo_rd_en,
    input  logic [DATA_W:0]           i_fifo_rd_data,
    input  logic                      i_fifo_empty,
    input  logic                      i_fifo_full,
    input  logic                      i_rd_req,
    output logic                      o_rd_valid,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic                      o_rd_last,
    output logic [N_SRC-1:0]          o_grant,
    output logic [CNT_W-1:0]          o_pkts_stored
);

    localparam int IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int LAST = last_bit_idx(DATA_W);

    wr_state_t         state_q, state_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [N_SRC-1:0]  gnt_q, gnt_d;
    op_t               last_op_q;
    logic              rd_vld_q;
    logic [CNT_W-1:0]  pkts_q;

    logic [N_SRC-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_vld;

    logic              src_vld_g, src_last_g;
    logic [DATA_W-1:0] src_dat_g;
    logic              pkt_done, pkts_avail, rd_ok, wr_pend, wr_win, rd_win;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req     (i_src_valid),
        .ptr     (rr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign src_vld_g  = i_src_valid[gidx_q];
    assign src_last_g = i_src_last[gidx_q];
    assign src_dat_g  = i_src_data[gidx_q*DATA_W +: DATA_W];

    // A packet whose last beat is arriving now is already consumed; without this a
    // back-to-back read could start on a partially stored packet behind it.
    assign pkt_done   = rd_vld_q & o_rd_last;
    assign pkts_avail = (pkts_q != '0) && !((pkts_q == CNT_W'(1)) && pkt_done);

    assign rd_ok   = i_rd_req & ~i_fifo_empty & (STORE_FWD ? pkts_avail : 1'b1);
    assign wr_pend = (state_q == ST_XFER) & src_vld_g & ~i_fifo_full;
    assign wr_win  = wr_pend & (~rd_ok   | (last_op_q == OP_READ));
    assign rd_win  = rd_ok   & (~wr_pend | (last_op_q == OP_WRITE));

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_XFER;
                    gidx_d  = arb_idx;
                    gnt_d   = arb_gnt;
                end
            end
            ST_XFER: begin
                if (wr_win && src_last_g) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = gidx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            gidx_q    <= '0;
            gnt_q     <= '0;
            rr_q      <= IW'(N_SRC - 1);
            last_op_q <= OP_READ;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            rd_vld_q <= rd_win;
            // Only contested cycles move the tie-break.
            if (wr_pend && rd_ok)
                last_op_q <= wr_win ? OP_WRITE : OP_READ;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pkts_q <= '0;
        end else begin
            case ({wr_win & src_last_g, pkt_done})
                2'b10:   if (pkts_q != '1) pkts_q <= pkts_q + 1'b1;
                2'b01:   if (pkts_q != '0) pkts_q <= pkts_q - 1'b1;
                default: pkts_q <= pkts_q;
            endcase
        end
    end

    assign o_src_ready    = gnt_q & {N_SRC{wr_win}};
    assign o_fifo_wr_en   = wr_win;
    assign o_fifo_wr_data = {src_last_g, src_dat_g};
    assign o_fifo_rd_en   = rd_win;
    assign o_rd_valid     = rd_vld_q;
    assign o_rd_data      = i_fifo_rd_data[DATA_W-1:0];
    assign o_rd_last      = i_fifo_rd_data[LAST];
    assign o_grant        = gnt_q;
    assign o_pkts_stored  = pkts_q;

endmodule

// File: tb/tb_pkt_fifo_sched.sv
// Directed bench for pkt_fifo_sched with a depth-8 FIFO model and per-source packet generators.
module tb_pkt_fifo_sched;

    localparam int N = 4;
    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N-1:0]    i_src_valid = '0;
    logic [N-1:0]    i_src_last = '0;
    logic [N*DW-1:0] i_src_data = '0;
    logic [N-1:0]    o_src_ready;
    logic            o_fifo_wr_en;
    logic [DW:0]     o_fifo_wr_data;
    logic            o_fifo_rd_en;
    logic [DW:0]     i_fifo_rd_data;
    logic            i_fifo_empty;
    logic            i_fifo_full;
    logic            i_rd_req = 1'b0;
    logic            o_rd_valid;
    logic [DW-1:0]   o_rd_data;
    logic            o_rd_last;
    logic [N-1:0]    o_grant;
    logic [12:0]     o_pkts_stored;

    always #5 i_clk = ~i_clk;

    pkt_fifo_sched #(.N_SRC(N), .DATA_W(DW), .CNT_W(13), .STORE_FWD(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_src_valid(i_src_valid), .i_src_last(i_src_last), .i_src_data(i_src_data),
        .o_src_ready(o_src_ready),
        .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wr_data(o_fifo_wr_data),
        .o_fifo_rd_en(o_fifo_rd_en), .i_fifo_rd_data(i_fifo_rd_data),
        .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full),
        .i_rd_req(i_rd_req), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_rd_last(o_rd_last), .o_grant(o_grant), .o_pkts_stored(o_pkts_stored)
    );

    // FIFO model: registered read data, reset by the same signal as the scheduler.
    logic [DW:0] mem [DEPTH];
    int          fcnt, wp, rp;
    logic [DW:0] wr_q [$];

    assign i_fifo_empty = (fcnt == 0);
    assign i_fifo_full  = (fcnt == DEPTH);

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            fcnt <= 0; wp <= 0; rp <= 0; i_fifo_rd_data <= '0;
        end else begin
            if (o_fifo_wr_en) begin
                mem[wp] <= o_fifo_wr_data;
                wp <= (wp + 1) % DEPTH;
                wr_q.push_back(o_fifo_wr_data);
            end
            if (o_fifo_rd_en) begin
                i_fifo_rd_data <= mem[rp];
                rp <= (rp + 1) % DEPTH;
            end
            fcnt <= fcnt + (o_fifo_wr_en ? 1 : 0) - (o_fifo_rd_en ? 1 : 0);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int          len [N];
    int          sent [N];
    logic [15:0] base [N];
    bit          en [N];
    bit          rep [N];

    logic [N-1:0] c_rdy, c_gnt;
    logic         c_wr, c_rd, c_rvld, c_rlast;
    logic [DW:0]  c_wdat;
    logic [DW-1:0] c_rdat;
    logic [12:0]  c_pkts;

    task automatic drive_srcs();
        for (int k = 0; k < N; k++) begin
            i_src_valid[k] = en[k] && (sent[k] < len[k]);
            i_src_last[k]  = (sent[k] == len[k] - 1);
            i_src_data[k*DW +: DW] = base[k] + 16'(sent[k]);
        end
    endtask

    // Capture at negedge, then advance generators on the beats the DUT accepted.
    task automatic run_cycle();
        @(negedge i_clk);
        c_rdy = o_src_ready; c_gnt = o_grant; c_wr = o_fifo_wr_en; c_rd = o_fifo_rd_en;
        c_wdat = o_fifo_wr_data; c_rvld = o_rd_valid; c_rlast = o_rd_last;
        c_rdat = o_rd_data; c_pkts = o_pkts_stored;
        n_cmp++;
        if ((c_wr & c_rd) !== 1'b0) begin
            n_err++; $display("FAIL port_exclusive: wr_en=%b rd_en=%b want not both", c_wr, c_rd);
        end
        @(posedge i_clk); #1;
        for (int k = 0; k < N; k++) begin
            if (c_rdy[k]) begin
                sent[k]++;
                if (rep[k] && sent[k] == len[k]) begin
                    sent[k] = 0;
                    base[k] = base[k] + 16'd1;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic do_reset();
        i_rst_n  = 1'b0;
        i_rd_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            len[k] = 0; sent[k] = 0; base[k] = '0; en[k] = 0; rep[k] = 0;
        end
        drive_srcs();
        repeat (2) @(posedge i_clk);
        #1;
        wr_q.delete();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run_cycle();
        n_cmp++; if (c_gnt !== 4'b0)   begin n_err++; $display("FAIL rst_grant got %h want 0", c_gnt); end
        n_cmp++; if (c_rvld !== 1'b0)  begin n_err++; $display("FAIL rst_rd_valid got %b want 0", c_rvld); end
        n_cmp++; if (c_pkts !== 13'd0) begin n_err++; $display("FAIL rst_pkts got %0d want 0", c_pkts); end
        n_cmp++; if (c_wr !== 1'b0)    begin n_err++; $display("FAIL rst_wr_en got %b want 0", c_wr); end
        n_cmp++; if (c_rd !== 1'b0)    begin n_err++; $display("FAIL rst_rd_en got %b want 0", c_rd); end
    endtask

    task automatic test_two_src();
        logic [3:0]  eg [9];
        logic [12:0] ep [9];
        logic [DW:0] ew [6];
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        ep = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd1, 13'd1, 13'd1, 13'd1, 13'd2};
        ew = '{17'h0A000, 17'h0A001, 17'h1A002, 17'h0C000, 17'h0C001, 17'h1C002};
        do_reset();
        en[0] = 1; len[0] = 3; base[0] = 16'hA000;
        en[2] = 1; len[2] = 3; base[2] = 16'hC000;
        drive_srcs();
        for (int c = 0; c < 9; c++) begin
            run_cycle();
            n_cmp++; if (c_gnt !== eg[c])  begin n_err++; $display("FAIL two_src_grant c%0d got %h want %h", c, c_gnt, eg[c]); end
            n_cmp++; if (c_pkts !== ep[c]) begin n_err++; $display("FAIL two_src_pkts c%0d got %0d want %0d", c, c_pkts, ep[c]); end
        end
        n_cmp++;
        if (wr_q.size() != 6) begin
            n_err++; $display("FAIL two_src_wr_count got %0d want 6", wr_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (wr_q[i] !== ew[i]) begin n_err++; $display("FAIL two_src_word%0d got %h want %h", i, wr_q[i], ew[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  eg;
        logic [DW:0] ewd;
        do_reset();
        for (int k = 0; k < N; k++) begin
            en[k] = 1; len[k] = 1; rep[k] = 1; base[k] = 16'(k << 8);
        end
        drive_srcs();
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            eg = (c % 2 == 1) ? 4'(1 << ((c / 2) % 4)) : 4'b0;
            n_cmp++; if (c_gnt !== eg) begin n_err++; $display("FAIL rr_grant c%0d got %h want %h", c, c_gnt, eg); end
            n_cmp++; if (c_wr !== 1'(c % 2)) begin n_err++; $display("FAIL rr_wr_en c%0d got %b want %0d", c, c_wr, c % 2); end
            if (c % 2 == 1) begin
                ewd = 17'h10000 | 17'(((c / 2) % 4) << 8) | 17'((c / 2) / 4);
                n_cmp++; if (c_wdat !== ewd) begin n_err++; $display("FAIL rr_data c%0d got %h want %h", c, c_wdat, ewd); end
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        en[0] = 1; len[0] = 6;  base[0] = 16'h3000;
        en[1] = 1; len[1] = 12; base[1] = 16'h4000;
        drive_srcs();
        for (int c = 0; c < 18; c++) begin
            run_cycle();
            if (c == 7) begin
                n_cmp++; if (c_pkts !== 13'd1) begin n_err++; $display("FAIL alt_pkts_before got %0d want 1", c_pkts); end
                i_rd_req = 1'b1;
            end
            if (c >= 8) begin
                n_cmp++; if (c_wr !== 1'(c % 2 == 0)) begin n_err++; $display("FAIL alt_wr c%0d got %b want %0d", c, c_wr, c % 2 == 0); end
                n_cmp++; if (c_rd !== 1'(c % 2 == 1)) begin n_err++; $display("FAIL alt_rd c%0d got %b want %0d", c, c_rd, c % 2 == 1); end
            end
            if (c == 10 || c == 12) begin
                n_cmp++;
                if (c_rvld !== 1'b1 || c_rdat !== 16'h3000 + 16'((c - 10) / 2)) begin
                    n_err++; $display("FAIL alt_rd_data c%0d got vld=%b %h want vld=1 %h", c, c_rvld, c_rdat, 16'h3000 + 16'((c - 10) / 2));
                end
            end
        end
        i_rd_req = 1'b0;
    endtask

    task automatic test_store_fwd();
        logic [12:0] ep;
        do_reset();
        i_rd_req = 1'b1;
        en[1] = 1; len[1] = 4; base[1] = 16'h5000;
        drive_srcs();
        for (int c = 0; c < 16; c++) begin
            run_cycle();
            if (c == 2) begin en[1] = 0; drive_srcs(); end
            if (c == 7) begin en[1] = 1; drive_srcs(); end
            n_cmp++; if (c_rd !== 1'(c >= 10 && c <= 13)) begin n_err++; $display("FAIL sf_rd_en c%0d got %b want %0d", c, c_rd, c >= 10 && c <= 13); end
            n_cmp++; if (c_rvld !== 1'(c >= 11 && c <= 14)) begin n_err++; $display("FAIL sf_rd_valid c%0d got %b want %0d", c, c_rvld, c >= 11 && c <= 14); end
            if (c >= 11 && c <= 14) begin
                n_cmp++; if (c_rdat !== 16'h5000 + 16'(c - 11)) begin n_err++; $display("FAIL sf_rd_data c%0d got %h want %h", c, c_rdat, 16'h5000 + 16'(c - 11)); end
                n_cmp++; if (c_rlast !== 1'(c == 14)) begin n_err++; $display("FAIL sf_rd_last c%0d got %b want %0d", c, c_rlast, c == 14); end
            end
            ep = (c >= 10 && c <= 14) ? 13'd1 : 13'd0;
            n_cmp++; if (c_pkts !== ep) begin n_err++; $display("FAIL sf_pkts c%0d got %0d want %0d", c, c_pkts, ep); end
        end
        i_rd_req = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        en[0] = 1; len[0] = 1;  base[0] = 16'h6100;
        en[1] = 1; len[1] = 10; base[1] = 16'h6200;
        drive_srcs();
        for (int c = 0; c < 15; c++) begin
            run_cycle();
            if (c >= 3 && c <= 9) begin
                n_cmp++; if (c_rdy !== 4'b0010) begin n_err++; $display("FAIL full_rdy_fill c%0d got %h want 2", c, c_rdy); end
            end
            if (c == 10 || c == 11 || c == 14) begin
                n_cmp++; if (c_rdy !== 4'b0) begin n_err++; $display("FAIL full_rdy_stall c%0d got %h want 0", c, c_rdy); end
                n_cmp++; if (c_gnt !== 4'b0010) begin n_err++; $display("FAIL full_grant_hold c%0d got %h want 2", c, c_gnt); end
                n_cmp++; if (c_wr !== 1'b0) begin n_err++; $display("FAIL full_wr_stall c%0d got %b want 0", c, c_wr); end
            end
            if (c == 11) i_rd_req = 1'b1;
            if (c == 12) begin
                n_cmp++; if (c_rd !== 1'b1 || c_wr !== 1'b0) begin n_err++; $display("FAIL full_read_slot got rd=%b wr=%b want rd=1 wr=0", c_rd, c_wr); end
            end
            if (c == 13) begin
                n_cmp++; if (c_wr !== 1'b1 || c_wdat !== 17'h06207) begin n_err++; $display("FAIL full_resume got wr=%b %h want wr=1 06207", c_wr, c_wdat); end
                n_cmp++; if (c_rvld !== 1'b1 || c_rdat !== 16'h6100 || c_rlast !== 1'b1) begin n_err++; $display("FAIL full_rd_word got vld=%b %h last=%b want 1 6100 1", c_rvld, c_rdat, c_rlast); end
            end
            if (c == 14) begin
                n_cmp++; if (c_pkts !== 13'd0 || c_rd !== 1'b0) begin n_err++; $display("FAIL full_pkts_after got %0d rd=%b want 0 rd=0", c_pkts, c_rd); end
            end
        end
        i_rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en[1] = 1; len[1] = 1; base[1] = 16'h7100;
        en[2] = 1; len[2] = 5; base[2] = 16'h7200;
        drive_srcs();
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            if (c == 4) begin
                i_rst_n = 1'b0;
                en[0] = 1; len[0] = 1; base[0] = 16'h7000;
                drive_srcs();
            end
            if (c == 5) begin
                n_cmp++; if (c_gnt !== 4'b0100 || c_pkts !== 13'd1) begin n_err++; $display("FAIL mid_pre got gnt=%h pkts=%0d want 4 1", c_gnt, c_pkts); end
                i_rst_n = 1'b1;
            end
            if (c == 6) begin
                n_cmp++; if (c_gnt !== 4'b0)   begin n_err++; $display("FAIL mid_grant got %h want 0", c_gnt); end
                n_cmp++; if (c_pkts !== 13'd0) begin n_err++; $display("FAIL mid_pkts got %0d want 0", c_pkts); end
                n_cmp++; if (c_rvld !== 1'b0)  begin n_err++; $display("FAIL mid_rd_valid got %b want 0", c_rvld); end
                n_cmp++; if (c_wr !== 1'b0)    begin n_err++; $display("FAIL mid_wr_en got %b want 0", c_wr); end
            end
            if (c == 7) begin
                n_cmp++; if (c_gnt !== 4'b0001) begin n_err++; $display("FAIL mid_restart got %h want 1", c_gnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_src();
        test_back_to_back();
        test_contention();
        test_store_fwd();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
